sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 173 +++++++++++++++++
 tb/tb_sram_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Behavioural SRAM slave: samples asynchronous-style SRAM strobes on fpga_clk and answers
// reads after RD_LAT cycles; writes are collected per byte lane and committed when the strobe ends.
module sram_responder #(
    parameter int          ADR_W  = 8,
    parameter int          RD_LAT = 2,
    parameter logic [15:0] FILL   = 16'h0BAD
) (
    input  logic             fpga_clk,
    input  logic             cpu_reset,
    input  logic [ADR_W-1:0] sram_adr_i,
    inout  wire  [15:0]      sram_dat_io,
    input  logic             sram_ce_on,
    input  logic             sram_we_on,
    input  logic             sram_oe_on,
    input  logic             sram_lbe_on,
    input  logic             sram_ube_on,
    output logic [15:0]      wr_count_o,
    output logic             err_o,
    output logic [1:0]       dbg_state_o
);
    localparam int DEPTH = 1 << ADR_W;

    typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RD_DRIVE = 2'd2, WR_ACTIVE = 2'd3} state_t;

    state_t           state_q, state_d;
    logic             s_ce_q, s_we_q, s_oe_q, s_lbe_q, s_ube_q;
    logic [ADR_W-1:0] s_adr_q;
    logic [3:0]       cnt_q, cnt_d;
    logic [ADR_W-1:0] rd_adr_q, rd_adr_d, wr_adr_q, wr_adr_d;
    logic [15:0]      hold_q, hold_d;
    logic [1:0]       seen_q, seen_d;
    logic [15:0]      wr_count_q, wr_count_d;
    logic             err_q, err_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [7:0]       mem_lo_q [DEPTH];
    logic [7:0]       mem_hi_q [DEPTH];
    logic [15:0]      mem_wdata_d, rd_word;
    logic             req_wr, req_rd, commit, commit_any, wr_entry, capture;
    logic             drive, drv_lo, drv_hi;

    always_ff @(posedge fpga_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_q    <= IDLE;
            s_ce_q     <= 1'b1;
            s_we_q     <= 1'b1;
            s_oe_q     <= 1'b1;
            s_lbe_q    <= 1'b1;
            s_ube_q    <= 1'b1;
            s_adr_q    <= '0;
            cnt_q      <= '0;
            rd_adr_q   <= '0;
            wr_adr_q   <= '0;
            hold_q     <= '0;
            seen_q     <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            s_ce_q     <= sram_ce_on;
            s_we_q     <= sram_we_on;
            s_oe_q     <= sram_oe_on;
            s_lbe_q    <= sram_lbe_on;
            s_ube_q    <= sram_ube_on;
            s_adr_q    <= sram_adr_i;
            cnt_q      <= cnt_d;
            rd_adr_q   <= rd_adr_d;
            wr_adr_q   <= wr_adr_d;
            hold_q     <= hold_d;
            seen_q     <= seen_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
        end
    end

    // Array contents survive reset; only the valid bits are cleared.
    always_ff @(posedge fpga_clk) begin
        if (commit_any) begin
            mem_lo_q[wr_adr_q] <= mem_wdata_d[7:0];
            mem_hi_q[wr_adr_q] <= mem_wdata_d[15:8];
        end
    end

    always_comb begin
        req_wr   = !s_ce_q && !s_we_q;
        req_rd   = !s_ce_q && s_we_q && !s_oe_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_adr_d = rd_adr_q;
        wr_adr_d = wr_adr_q;
        case (state_q)
            IDLE: begin
                if (req_wr) begin
                    state_d  = WR_ACTIVE;
                    wr_adr_d = s_adr_q;
                end else if (req_rd) begin
                    rd_adr_d = s_adr_q;
                    state_d  = (RD_LAT <= 1) ? RD_DRIVE : RD_WAIT;
                    cnt_d    = 4'(RD_LAT - 1);
                end
            end
            RD_WAIT, RD_DRIVE: begin
                if (s_ce_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!s_we_q) begin
                    state_d  = WR_ACTIVE;
                    wr_adr_d = s_adr_q;
                    cnt_d    = '0;
                end else if (s_oe_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (s_adr_q != rd_adr_q) begin
                    rd_adr_d = s_adr_q;
                    state_d  = (RD_LAT <= 1) ? RD_DRIVE : RD_WAIT;
                    cnt_d    = 4'(RD_LAT - 1);
                end else if (state_q == RD_WAIT) begin
                    // The decrement that reaches zero is the one that starts driving.
                    if (cnt_q <= 4'd1) begin
                        state_d = RD_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            WR_ACTIVE: begin
                if (s_we_q || s_ce_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        commit     = (state_q == WR_ACTIVE) && (s_we_q || s_ce_q);
        commit_any = commit && (seen_q != 2'b00);
        wr_entry   = (state_d == WR_ACTIVE) && (state_q != WR_ACTIVE);
        capture    = wr_entry || ((state_q == WR_ACTIVE) && !commit);
        hold_d     = hold_q;
        seen_d     = wr_entry ? 2'b00 : seen_q;
        if (capture && !s_lbe_q) begin
            hold_d[7:0] = sram_dat_io[7:0];
            seen_d[0]   = 1'b1;
        end
        if (capture && !s_ube_q) begin
            hold_d[15:8] = sram_dat_io[15:8];
            seen_d[1]    = 1'b1;
        end
        err_d = err_q || ((state_q == WR_ACTIVE) && !commit && (s_adr_q != wr_adr_q));
        wr_count_d = wr_count_q + {15'd0, commit_any};
        // Lanes never captured keep the old word, or FILL if the word was never written.
        mem_wdata_d = valid_q[wr_adr_q] ? {mem_hi_q[wr_adr_q], mem_lo_q[wr_adr_q]} : FILL;
        if (seen_q[0]) mem_wdata_d[7:0]  = hold_q[7:0];
        if (seen_q[1]) mem_wdata_d[15:8] = hold_q[15:8];
        valid_d = valid_q;
        if (commit_any) valid_d[wr_adr_q] = 1'b1;
    end

    always_comb begin
        rd_word = valid_q[rd_adr_q] ? {mem_hi_q[rd_adr_q], mem_lo_q[rd_adr_q]} : FILL;
        // Raw strobes gate the drive so the bus is released without waiting for a sample.
        drive   = (state_q == RD_DRIVE) && (s_adr_q == rd_adr_q)
                  && !sram_ce_on && !sram_oe_on && sram_we_on;
        drv_lo  = drive && !s_lbe_q;
        drv_hi  = drive && !s_ube_q;
    end

    assign sram_dat_io = {drv_hi ? rd_word[15:8] : 8'hzz, drv_lo ? rd_word[7:0] : 8'hzz};
    assign wr_count_o  = wr_count_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: each step drives SRAM strobes on the falling edge
// and checks hand-computed values; released bus lanes read as 1s through pullups.
module tb_sram_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  adr;
    logic        ce, we, oe, lbe, ube;
    logic [15:0] tb_dat;
    logic        tb_drv;
    wire  [15:0] sram_dat_io;
    logic [15:0] wr_count;
    logic        err;
    logic [1:0]  dbg_state;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    assign sram_dat_io = tb_drv ? tb_dat : 16'hzzzz;
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (sram_dat_io[i]);
    end

    sram_responder dut (
        .fpga_clk    (clk),
        .cpu_reset   (rst),
        .sram_adr_i  (adr),
        .sram_dat_io (sram_dat_io),
        .sram_ce_on  (ce),
        .sram_we_on  (we),
        .sram_oe_on  (oe),
        .sram_lbe_on (lbe),
        .sram_ube_on (ube),
        .wr_count_o  (wr_count),
        .err_o       (err),
        .dbg_state_o (dbg_state)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_bus();
        ce = 1'b1; we = 1'b1; oe = 1'b1; lbe = 1'b0; ube = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic l, input logic u, input logic o);
        adr = a; tb_dat = d; tb_drv = 1'b1; lbe = l; ube = u;
        ce = 1'b0; we = 1'b0; oe = o;
        tick(2);
        we = 1'b1; oe = 1'b1;
        tick(1);
        idle_bus();
        tick(2);
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input logic l, input logic u, input logic [15:0] exp);
        adr = a; lbe = l; ube = u; ce = 1'b0; we = 1'b1; oe = 1'b0;
        tick(3);
        chk(tag, sram_dat_io, exp);
        idle_bus();
        tick(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; adr = '0; tb_dat = '0;
        idle_bus();
        tick(2);
        chk("rst_count", wr_count, 16'h0000);
        chk("rst_err", {15'd0, err}, 16'h0000);
        chk("rst_bus", sram_dat_io, 16'hFFFF);
        chk("rst_state", {14'd0, dbg_state}, 16'h0000);
        rst = 1'b0;
        tick(1);

        // Never-written word: two released cycles after the sample, then FILL.
        adr = 8'h10; ce = 1'b0; we = 1'b1; oe = 1'b0;
        tick(1); chk("rd10_z1", sram_dat_io, 16'hFFFF);
        tick(1); chk("rd10_z2", sram_dat_io, 16'hFFFF);
        tick(1); chk("rd10_fill", sram_dat_io, 16'h0BAD);
        idle_bus();
        tick(2);

        do_write(8'h05, 16'h1234, 1'b0, 1'b0, 1'b1);
        chk("wr05_count", wr_count, 16'd1);
        do_read("rd05", 8'h05, 1'b0, 1'b0, 16'h1234);

        do_write(8'h06, 16'hABCD, 1'b0, 1'b1, 1'b1);
        chk("wr06_count", wr_count, 16'd2);
        do_read("rd06_both", 8'h06, 1'b0, 1'b0, 16'h0BCD);
        do_read("rd06_upper", 8'h06, 1'b1, 1'b0, 16'h0BFF);

        do_write(8'h0D, 16'h3333, 1'b0, 1'b0, 1'b0);
        chk("wr0d_count", wr_count, 16'd3);
        chk("wr0d_noerr", {15'd0, err}, 16'h0000);
        do_read("rd0d", 8'h0D, 1'b0, 1'b0, 16'h3333);

        // Address change during a read restarts the latency.
        adr = 8'h05; ce = 1'b0; we = 1'b1; oe = 1'b0;
        tick(3); chk("chg_rd05", sram_dat_io, 16'h1234);
        adr = 8'h10;
        tick(1); chk("chg_rel", sram_dat_io, 16'hFFFF);
        tick(1); chk("chg_wait", sram_dat_io, 16'hFFFF);
        tick(1); chk("chg_rd10", sram_dat_io, 16'h0BAD);
        oe = 1'b1;
        #1 chk("oe_release", sram_dat_io, 16'hFFFF);
        idle_bus();
        tick(2);

        // Address change mid-write flags an error; data lands at the entry address.
        adr = 8'h07; tb_dat = 16'h5555; tb_drv = 1'b1; ce = 1'b0; we = 1'b0; oe = 1'b1;
        tick(2);
        adr = 8'h08;
        tick(2); chk("werr_set", {15'd0, err}, 16'h0001);
        we = 1'b1;
        tick(1);
        idle_bus();
        tick(2);
        chk("werr_count", wr_count, 16'd4);
        chk("werr_held", {15'd0, err}, 16'h0001);
        do_read("rd07", 8'h07, 1'b0, 1'b0, 16'h5555);
        do_read("rd08", 8'h08, 1'b0, 1'b0, 16'h0BAD);

        // we pulses 0-1-0: first write commits, second starts right after.
        adr = 8'h0A; tb_dat = 16'h1111; tb_drv = 1'b1; ce = 1'b0; we = 1'b0; oe = 1'b1;
        tick(1);
        we = 1'b1;
        tick(1);
        we = 1'b0; adr = 8'h0B; tb_dat = 16'h2222;
        tick(1); chk("pulse_commit", wr_count, 16'd5);
        tick(1); chk("pulse_reenter", {14'd0, dbg_state}, 16'h0003);
        we = 1'b1;
        tick(1);
        idle_bus();
        tick(2);
        chk("pulse_count", wr_count, 16'd6);
        do_read("rd0a", 8'h0A, 1'b0, 1'b0, 16'h1111);
        do_read("rd0b", 8'h0B, 1'b0, 1'b0, 16'h2222);

        do_write(8'h0C, 16'h7777, 1'b1, 1'b1, 1'b1);
        chk("nolane_count", wr_count, 16'd6);
        do_read("rd0c", 8'h0C, 1'b0, 1'b0, 16'h0BAD);

        // Reset in the middle of a write.
        adr = 8'h09; tb_dat = 16'h9999; tb_drv = 1'b1; ce = 1'b0; we = 1'b0; oe = 1'b1;
        tick(2);
        rst = 1'b1;
        #1;
        chk("wrst_count", wr_count, 16'h0000);
        chk("wrst_err", {15'd0, err}, 16'h0000);
        idle_bus();
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("wrst_count_after", wr_count, 16'h0000);
        do_read("rst_rd09", 8'h09, 1'b0, 1'b0, 16'h0BAD);
        do_read("rst_rd05", 8'h05, 1'b0, 1'b0, 16'h0BAD);
        do_read("rst_rd07", 8'h07, 1'b0, 1'b0, 16'h0BAD);
        do_read("rst_rd0a", 8'h0A, 1'b0, 1'b0, 16'h0BAD);

        // Reset in the middle of a driven read releases the bus at once.
        adr = 8'h05; ce = 1'b0; we = 1'b1; oe = 1'b0;
        tick(3); chk("rrst_drive", sram_dat_io, 16'h0BAD);
        rst = 1'b1;
        #1 chk("rrst_release", sram_dat_io, 16'hFFFF);
        idle_bus();
        tick(1);
        rst = 1'b0;
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
